// File: rtl/leb128_encoder_pkg.sv
// Shared LEB128 definitions: length limits, encoder FSM states and the value-type
// codes the operand stack uses for i32/i64.
package leb128_encoder_pkg;

  localparam int LEB128_MAX_I32 = 5;
  localparam int LEB128_MAX_I64 = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    VT_I32 = 2'b00,
    VT_I64 = 2'b01
  } val_type_e;

  // i32 operands occupy the low word and are widened to the 64-bit working width.
  function automatic logic [63:0] sign_extend(input val_type_e vt, input logic [63:0] v);
    return (vt == VT_I64) ? v : {{32{v[31]}}, v[31:0]};
  endfunction

endpackage

// File: rtl/leb128_encoder_chunk.sv
// Forms one signed-LEB128 byte from the low group of the shift register and
// decides whether the remaining bits are pure sign extension.
module leb128_chunk (
  input  logic [63:0] sr_i,
  output logic [7:0]  byte_o,
  output logic        last_o
);

  logic [63:0] rest;

  always_comb begin
    rest   = $signed(sr_i) >>> 7;
    // Stop once the rest is all sign bits and bit 6 already carries that sign.
    last_o = ((rest == '0) && !sr_i[6]) || ((rest == '1) && sr_i[6]);
    byte_o = {~last_o, sr_i[6:0]};
  end

endmodule

// File: rtl/leb128_encoder.sv
// Streaming signed-LEB128 encoder: accepts one i32/i64 operand and emits its
// bytes least-significant group first under valid/ready handshakes.
module leb128_encoder
  import leb128_encoder_pkg::*;
#(
  parameter int MAX_BYTES = LEB128_MAX_I64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_value,
  input  logic        in_is64,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_last,
  output logic [3:0]  out_len
);

  state_e      state_q, state_d;
  logic [63:0] sr_q, sr_d;
  logic [3:0]  len_q, len_d;
  val_type_e   vtype_q, vtype_d;

  logic [7:0]  chunk_byte;
  logic        chunk_last;
  logic        limit_hit;

  leb128_chunk u_chunk (
    .sr_i   (sr_q),
    .byte_o (chunk_byte),
    .last_o (chunk_last)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      len_q   <= '0;
      vtype_q <= VT_I32;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      len_q   <= len_d;
      vtype_q <= vtype_d;
    end
  end

  always_comb begin
    // NOTE: hold-by-default assignments before the case keep this block free
    // of inferred latches on paths that do not update a signal.
    state_d = state_q;
    sr_d    = sr_q;
    len_d   = len_q;
    vtype_d = vtype_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          vtype_d = in_is64 ? VT_I64 : VT_I32;
          sr_d    = sign_extend(vtype_d, in_value);
          len_d   = 4'd1;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          if (out_last) begin
            state_d = ST_IDLE;
          end else begin
            sr_d  = $signed(sr_q) >>> 7;
            len_d = len_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_EMIT);
    out_len   = len_q;
    // Hard stop at the type's maximum length so the index can never wrap.
    limit_hit = (len_q == ((vtype_q == VT_I64) ? 4'(MAX_BYTES) : 4'(LEB128_MAX_I32)));
    out_last  = out_valid && (chunk_last || limit_hit);
    out_byte  = out_valid ? {chunk_byte[7] && !limit_hit, chunk_byte[6:0]} : 8'h00;
  end

endmodule

// File: doc/leb128_encoder.md
LEB128_ENCODER -- requirements
Module: leb128_encoder

Interface
REQ-001 SHALL have a parameter MAX_BYTES, default 10, giving the maximum encoded length (i64 worst case).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: in_value and in_is64 are valid this cycle.
REQ-005 SHALL have port in_ready, output, 1 bit: the encoder accepts a value this cycle.
REQ-006 SHALL have port in_value, input, 64 bits: the signed integer to encode.
REQ-007 SHALL have port in_is64, input, 1 bit: 1 = i64 operand; 0 = i32 operand, taken as in_value[31:0] sign-extended.
REQ-008 SHALL have port out_valid, output, 1 bit: out_byte holds an encoded byte.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts out_byte this cycle.
REQ-010 SHALL have port out_byte, output, 8 bits: the current signed-LEB128 byte, least-significant group first.
REQ-011 SHALL have port out_last, output, 1 bit: out_byte is the final byte of the encoding.
REQ-012 SHALL have port out_len, output, 4 bits: 1-based index of the current byte; equals the total length when out_last=1.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and EMIT.
REQ-014 In IDLE, in_ready SHALL be 1 and out_valid 0; in EMIT, in_ready SHALL be 0.
REQ-015 On an in_valid && in_ready cycle, the FSM SHALL latch the sign-extended 64-bit operand into a shift register, set the byte index to 1, and enter EMIT; out_valid SHALL rise the next cycle (latency 1).
REQ-016 Each emitted byte SHALL be: bit[6:0] = sr[6:0]; bit7 = ~last.
REQ-017 last SHALL be 1 when either condition holds:
- arithmetic sr>>>7 is all-zeros and sr[6]=0;
- arithmetic sr>>>7 is all-ones and sr[6]=1.
REQ-018 out_byte, out_last and out_len SHALL be held stable while out_valid && !out_ready (backpressure).
REQ-019 On out_valid && out_ready && !out_last, the FSM SHALL:
- arithmetic-shift sr right by 7;
- increment out_len;
- present the next byte the following cycle.
REQ-020 On out_valid && out_ready && out_last, the FSM SHALL return to IDLE, giving one bubble cycle before the next accept.
REQ-021 Encoded length SHALL never exceed 5 bytes for i32 operands or MAX_BYTES for i64 operands; out_len SHALL never wrap.
REQ-022 in_valid asserted during EMIT SHALL be ignored and SHALL NOT disturb the shift register.
REQ-023 Encoding SHALL be bit-exact with the codebase's LEB128 decoder, so that unpack_i64 of the emitted bytes returns the original value and out_len.

Reset
REQ-024 While reset=0, the block SHALL force state=IDLE, out_valid=0, out_last=0, out_len=0, out_byte=0 and sr=0, asynchronously.
REQ-025 Reset asserted mid-EMIT SHALL abort the encoding; no further bytes of it SHALL be emitted.
REQ-026 After reset deasserts, in_ready SHALL be 1 on the first clock.

Structure
REQ-027 A shared package SHALL hold:
- the constants LEB128_MAX_I32=5 and LEB128_MAX_I64=10;
- the FSM state enum;
- the 2-bit value-type codes shared with the stack (i32, i64).
REQ-028 The termination test and byte formation SHALL be one combinational sub-module, leb128_chunk, with input sr[63:0] and outputs byte[7:0] and last.
REQ-029 The rest of the block SHALL be a single sequential module.

Verification
REQ-030 i32 value 0 -> one byte 0x00, out_last=1, out_len=1.
REQ-031 i32 -1 -> 0x7F, len 1; i32 64 -> 0xC0 0x00, len 2; i32 -65 -> 0xBF 0x7F.
REQ-032 i32 624485 -> 0xE5 0x8E 0x26; i32 -123456 -> 0xC0 0xBB 0x78; i32 0x80000000 -> 0x80 0x80 0x80 0x80 0x78, len 5.
REQ-033 i64 0x8000000000000000 -> 0x80 x9 then 0x7F, out_len=10 on the last byte; i64 0x7FFFFFFFFFFFFFFF -> 0xFF x9 then 0x00.
REQ-034 Backpressure test: encode 624485 with out_ready=0 for 3 cycles on byte 2 -> 0x8E held stable, the sequence is unchanged, and in_valid pulses during EMIT are ignored.
REQ-035 Reset test: reset=0 asserted after byte 1 of a 3-byte encoding -> out_valid=0 immediately and in_ready=1 on the first clock after release; random loopback of 10k values through unpack_i64 -> values and lengths match.
